// File: rtl/sample_averager_if.sv
// Bundle between the sample averager, its upstream sample buffer and the downstream consumer.
// The slave modport is the averager's view; master is the environment's view.
interface sample_averager_if #(
  parameter int DATA_WIDTH = 12,
  parameter int LOG2_N     = 3
);
  logic [DATA_WIDTH-1:0] fifo_data;
  logic                  fifo_empty;
  logic                  fifo_rd;
  logic [DATA_WIDTH-1:0] avg_out;
  logic                  avg_valid;
  logic                  avg_ready;
  logic [LOG2_N-1:0]     sample_cnt;

  modport master (
    output fifo_data, fifo_empty, avg_ready,
    input  fifo_rd, avg_out, avg_valid, sample_cnt
  );

  modport slave (
    input  fifo_data, fifo_empty, avg_ready,
    output fifo_rd, avg_out, avg_valid, sample_cnt
  );
endinterface

// File: rtl/sample_averager.sv
// Decimate-by-2^LOG2_N stage: pops samples from the buffer, sums a block and emits the
// truncated block mean on a valid/ready port.
module sample_averager #(
  parameter int DATA_WIDTH = 12,
  parameter int LOG2_N     = 3
) (
  input  logic               clk,
  input  logic               rst,
  sample_averager_if.slave   bus
);
  localparam int ACC_W = DATA_WIDTH + LOG2_N;
  localparam logic [LOG2_N-1:0] LAST_IDX = {LOG2_N{1'b1}};

  typedef enum logic [1:0] {FETCH, WAIT, DONE} state_t;

  state_t                state;
  state_t                state_nxt;
  logic [ACC_W-1:0]      acc;
  logic [ACC_W-1:0]      sum;
  logic [LOG2_N-1:0]     cnt;
  logic [DATA_WIDTH-1:0] avg;
  logic                  vld;
  logic                  rd;
  logic                  last;

  function automatic logic [DATA_WIDTH-1:0] mean_trunc(input logic [ACC_W-1:0] total);
    return total[ACC_W-1:LOG2_N];
  endfunction

  assign sum  = acc + ACC_W'(bus.fifo_data);
  assign last = (cnt == LAST_IDX);

  always_comb begin
    state_nxt = state;
    rd        = 1'b0;
    case (state)
      FETCH: begin
        rd = !bus.fifo_empty && !rst;
        if (!bus.fifo_empty) state_nxt = WAIT;
      end
      WAIT:    state_nxt = last ? DONE : FETCH;
      DONE:    if (vld && bus.avg_ready) state_nxt = FETCH;
      default: state_nxt = FETCH;
    endcase
  end

  // Data requested in FETCH is on fifo_data during WAIT; capture it at the end of WAIT
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= FETCH;
      acc   <= '0;
      cnt   <= '0;
      avg   <= '0;
      vld   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == WAIT) begin
        cnt <= cnt + 1'b1;
        if (last) begin
          acc <= '0;
          avg <= mean_trunc(sum);
          vld <= 1'b1;
        end else begin
          acc <= sum;
        end
      end
      if (state == DONE && vld && bus.avg_ready) vld <= 1'b0;
    end
  end

  assign bus.fifo_rd    = rd;
  assign bus.avg_out    = avg;
  assign bus.avg_valid  = vld;
  assign bus.sample_cnt = cnt;
endmodule

// File: tb/tb_sample_averager.sv
// Bench for sample_averager: queue-backed buffer models, a block-mean scoreboard, a vector
// table and hand-written sequences for latency, backpressure and reset.
module tb_sample_averager;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sample_averager_if #(.DATA_WIDTH(12), .LOG2_N(3)) bus ();
  sample_averager_if #(.DATA_WIDTH(12), .LOG2_N(1)) bus1 ();

  sample_averager #(.DATA_WIDTH(12), .LOG2_N(3)) dut  (.clk(clk), .rst(rst), .bus(bus.slave));
  sample_averager #(.DATA_WIDTH(12), .LOG2_N(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));

  typedef struct {
    logic [7:0][11:0] s;
    logic [11:0]      exp;
    bit               gate;
  } vec_t;

  int checks = 0;
  int errors = 0;
  int viol = 0, viol1 = 0;
  bit hold = 1'b1, gate = 1'b0;
  logic [11:0] q[$], q1[$], blk[$], blk1[$], expq[$], exp1[$];

  task automatic check(input string name, input int got, input int want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, got, want);
    end
  endtask

  function automatic logic [11:0] model_mean(input logic [11:0] s[$], input int l2);
    int total = 0;
    foreach (s[i]) total += int'(s[i]);
    return 12'(total >> l2);
  endfunction

  function automatic vec_t mk(input int base, input int step, input int e, input bit g);
    vec_t r;
    for (int i = 0; i < 8; i++) r.s[i] = 12'(base + step * i);
    r.exp  = 12'(e);
    r.gate = g;
    return r;
  endfunction

  // Buffer model for the N=8 instance: data appears the cycle after a read request
  initial begin
    bit rd_pend;
    logic [11:0] d;
    bus.fifo_data  = '0;
    bus.fifo_empty = 1'b1;
    forever begin
      @(negedge clk);
      rd_pend = bus.fifo_rd;
      if (bus.fifo_rd && bus.fifo_empty) viol++;
      @(posedge clk);
      #1;
      if (rd_pend && q.size() > 0) begin
        d = q.pop_front();
        bus.fifo_data = d;
        blk.push_back(d);
        if (blk.size() == 8) begin
          expq.push_back(model_mean(blk, 3));
          blk.delete();
        end
      end
      bus.fifo_empty = (q.size() == 0) || hold || (gate && ($urandom_range(0, 1) == 1));
    end
  end

  // Buffer model for the N=2 instance
  initial begin
    bit rd_pend;
    logic [11:0] d;
    bus1.fifo_data  = '0;
    bus1.fifo_empty = 1'b1;
    forever begin
      @(negedge clk);
      rd_pend = bus1.fifo_rd;
      if (bus1.fifo_rd && bus1.fifo_empty) viol1++;
      @(posedge clk);
      #1;
      if (rd_pend && q1.size() > 0) begin
        d = q1.pop_front();
        bus1.fifo_data = d;
        blk1.push_back(d);
        if (blk1.size() == 2) begin
          exp1.push_back(model_mean(blk1, 1));
          blk1.delete();
        end
      end
      bus1.fifo_empty = (q1.size() == 0) || ($urandom_range(0, 3) == 0);
    end
  end

  // Scoreboards: every accepted output must equal the mean of the next popped block
  initial forever begin
    @(negedge clk);
    if (!rst && bus.avg_valid && bus.avg_ready) begin
      if (expq.size() == 0) check("unexpected_output", 1, 0);
      else check("model_avg", bus.avg_out, expq.pop_front());
    end
    if (!rst && bus1.avg_valid && bus1.avg_ready) begin
      if (exp1.size() == 0) check("unexpected_output_n2", 1, 0);
      else check("model_avg_n2", bus1.avg_out, exp1.pop_front());
    end
  end

  task automatic set_ready(input logic r);
    @(posedge clk);
    #2;
    bus.avg_ready = r;
  endtask

  task automatic wait_valid(input string name);
    bit found = 1'b0;
    for (int k = 0; k < 500; k++) begin
      @(negedge clk);
      if (bus.avg_valid) begin
        found = 1'b1;
        break;
      end
    end
    check(name, int'(found), 1);
  endtask

  task automatic apply(input vec_t v, input int idx);
    gate = v.gate;
    for (int i = 0; i < 8; i++) q.push_back(v.s[i]);
    wait_valid($sformatf("table%0d_valid", idx));
    check($sformatf("table%0d_avg", idx), bus.avg_out, v.exp);
    @(negedge clk);
    gate = 1'b0;
  endtask

  task automatic drain(input string name);
    bit done = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (q.size() == 0 && blk.size() == 0 && expq.size() == 0 && !bus.avg_valid &&
          q1.size() == 0 && blk1.size() == 0 && exp1.size() == 0 && !bus1.avg_valid) begin
        done = 1'b1;
        break;
      end
    end
    check(name, int'(done), 1);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
  endtask

  task automatic release_reset();
    expq.delete();
    blk.delete();
    q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  vec_t vecs[5];

  initial begin
    int first, vat, rdcnt;
    logic [11:0] held;
    bit stable;

    vecs[0] = mk(12'hFFF, 0, 12'hFFF, 1'b0);
    vecs[1] = mk(0, 0, 0, 1'b0);
    vecs[2] = mk(10, 10, 45, 1'b1);
    vecs[3] = mk(100, 7, 124, 1'b1);
    vecs[4] = mk(12'hFF0, 1, 4083, 1'b0);

    rst = 1'b1;
    bus.avg_ready  = 1'b0;
    bus1.avg_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_avg_out", bus.avg_out, 0);
    check("reset_avg_valid", bus.avg_valid, 0);
    check("reset_fifo_rd", bus.fifo_rd, 0);
    check("reset_sample_cnt", bus.sample_cnt, 0);
    rst = 1'b0;

    // Preloaded 0..7, first read to valid must be 16 cycles with 8 read pulses
    bus.avg_ready = 1'b1;
    for (int i = 0; i < 8; i++) q.push_back(12'(i));
    repeat (2) @(negedge clk);
    hold = 1'b0;
    first = -1; vat = -1; rdcnt = 0;
    for (int k = 0; k < 100 && vat < 0; k++) begin
      @(negedge clk);
      if (bus.fifo_rd) begin
        if (first < 0) first = k;
        rdcnt++;
      end
      if (bus.avg_valid) vat = k;
    end
    check("latency", vat - first, 16);
    check("rd_pulses", rdcnt, 8);
    check("avg_0_to_7", bus.avg_out, 3);
    @(negedge clk);
    check("valid_one_cycle", bus.avg_valid, 0);

    foreach (vecs[i]) apply(vecs[i], i);

    // Backpressure: output frozen, no reads, then release
    set_ready(1'b0);
    for (int i = 0; i < 8; i++) q.push_back(12'(200 + i));
    for (int i = 0; i < 8; i++) q.push_back(12'd300);
    wait_valid("bp_valid");
    held = bus.avg_out;
    stable = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.avg_out != held || !bus.avg_valid || bus.fifo_rd) stable = 1'b0;
    end
    check("bp_stable", int'(stable), 1);
    check("bp_avg", bus.avg_out, 203);
    set_ready(1'b1);
    @(negedge clk);
    @(negedge clk);
    check("bp_valid_drop", bus.avg_valid, 0);
    check("bp_fetch_resume", bus.fifo_rd, 1);
    wait_valid("bp_second_valid");
    check("bp_second_avg", bus.avg_out, 300);
    @(negedge clk);

    // Reset after 5 of 8 samples discards the partial sum
    for (int i = 0; i < 5; i++) q.push_back(12'(1000 + i));
    repeat (20) @(negedge clk);
    check("partial_cnt", bus.sample_cnt, 5);
    pulse_reset();
    check("partial_rst_cnt", bus.sample_cnt, 0);
    check("partial_rst_avg", bus.avg_out, 0);
    check("partial_rst_rd", bus.fifo_rd, 0);
    release_reset();
    apply(mk(1, 1, 4, 1'b0), 5);

    // Reset while an output is pending drops avg_valid without a clock edge
    set_ready(1'b0);
    for (int i = 0; i < 8; i++) q.push_back(12'd50);
    wait_valid("async_valid");
    check("async_pre_avg", bus.avg_out, 50);
    pulse_reset();
    check("async_valid_drop", bus.avg_valid, 0);
    check("async_avg_clear", bus.avg_out, 0);
    release_reset();

    // Random samples, random buffer stalls, random downstream ready
    gate = 1'b1;
    for (int b = 0; b < 6; b++)
      for (int i = 0; i < 8; i++) q.push_back(12'($urandom_range(0, 4095)));
    for (int k = 0; k < 300; k++) set_ready(1'($urandom_range(0, 1)));
    set_ready(1'b1);
    drain("random_drain");
    gate = 1'b0;

    // N=2 instance: truncation of 3.5 and random pairs
    q1.push_back(12'd3);
    q1.push_back(12'd4);
    begin
      bit found = 1'b0;
      for (int k = 0; k < 100; k++) begin
        @(negedge clk);
        if (bus1.avg_valid) begin
          found = 1'b1;
          break;
        end
      end
      check("n2_valid", int'(found), 1);
      check("n2_trunc", bus1.avg_out, 3);
    end
    for (int i = 0; i < 20; i++) q1.push_back(12'($urandom_range(0, 4095)));
    drain("n2_drain");

    check("no_read_when_empty", viol, 0);
    check("no_read_when_empty_n2", viol1, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
